// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  localparam int unsigned DEPTH_DEF      = 3;
  localparam int unsigned REG_AW_DEF     = 5;
  localparam int unsigned LOAD_READY_DEF = 1;
  localparam int unsigned FWD_RF         = 0;
  // Entry rd field is sized for the widest supported register address; narrower ones are zero-extended.
  localparam int unsigned REG_AW_MAX     = 8;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  is_load;
  } entry_t;

  function automatic int unsigned fwd_sel_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_match.sv
// Priority encoder: youngest valid tracking slot whose rd matches one source register.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned SLOT_W = $clog2(DEPTH)
) (
  input  entry_t [DEPTH-1:0]  pipe_i,
  input  logic [REG_AW-1:0]   src_i,
  input  logic                use_i,
  output logic                hit_o,
  output logic [SLOT_W-1:0]   slot_o,
  output logic                is_load_o
);

  // Scan oldest to youngest so the lowest matching index is the one left standing.
  always_comb begin
    hit_o     = 1'b0;
    slot_o    = '0;
    is_load_o = 1'b0;
    if (use_i && (src_i != '0)) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (pipe_i[k].valid && (pipe_i[k].rd == REG_AW_MAX'(src_i))) begin
          hit_o     = 1'b1;
          slot_o    = SLOT_W'(k);
          is_load_o = pipe_i[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks in-flight writers, selects forwarding sources,
// detects load-use stalls and applies taken-branch squashes.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned LOAD_READY  = LOAD_READY_DEF,
  parameter int unsigned FLUSH_SLOTS = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic                            id_valid,
  input  logic [REG_AW-1:0]               id_rs1,
  input  logic [REG_AW-1:0]               id_rs2,
  input  logic                            id_use_rs1,
  input  logic                            id_use_rs2,
  input  logic [REG_AW-1:0]               id_rd,
  input  logic                            id_reg_write,
  input  logic                            id_is_load,
  input  logic                            br_taken,
  output logic                            stall,
  output logic                            flush,
  output logic [DEPTH-1:0]                flush_mask,
  output logic [fwd_sel_w(DEPTH)-1:0]     fwd_sel_rs1,
  output logic [fwd_sel_w(DEPTH)-1:0]     fwd_sel_rs2,
  output logic [CNT_W-1:0]                stall_cnt
);

  localparam int unsigned SEL_W  = fwd_sel_w(DEPTH);
  localparam int unsigned SLOT_W = $clog2(DEPTH);
  localparam logic [DEPTH-1:0] SQUASH_MASK = DEPTH'((1 << FLUSH_SLOTS) - 1);

  entry_t [DEPTH-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic              hit1, hit2, ld1, ld2;
  logic [SLOT_W-1:0] slot1, slot2;
  logic              load_use_c;
  entry_t            id_entry;

  fwd_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SLOT_W(SLOT_W)) u_match_rs1 (
    .pipe_i    (pipe_q),
    .src_i     (id_rs1),
    .use_i     (id_use_rs1),
    .hit_o     (hit1),
    .slot_o    (slot1),
    .is_load_o (ld1)
  );

  fwd_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .SLOT_W(SLOT_W)) u_match_rs2 (
    .pipe_i    (pipe_q),
    .src_i     (id_rs2),
    .use_i     (id_use_rs2),
    .hit_o     (hit2),
    .slot_o    (slot2),
    .is_load_o (ld2)
  );

  // A load is only hazardous while it sits in a slot whose result is not yet forwardable.
  always_comb begin
    load_use_c = id_valid &&
                 ((hit1 && ld1 && (slot1 < SLOT_W'(LOAD_READY))) ||
                  (hit2 && ld2 && (slot2 < SLOT_W'(LOAD_READY))));
    flush       = br_taken;
    stall       = load_use_c && !br_taken;
    flush_mask  = br_taken ? SQUASH_MASK : '0;
    fwd_sel_rs1 = SEL_W'(FWD_RF);
    fwd_sel_rs2 = SEL_W'(FWD_RF);
    if (hit1 && !load_use_c) fwd_sel_rs1 = SEL_W'(slot1) + SEL_W'(1);
    if (hit2 && !load_use_c) fwd_sel_rs2 = SEL_W'(slot2) + SEL_W'(1);
  end

  // Squashed slots are cleared before they shift; ID enters only when neither stalled nor flushed.
  always_comb begin
    id_entry         = '0;
    id_entry.valid   = id_valid && id_reg_write && (id_rd != '0);
    id_entry.rd      = REG_AW_MAX'(id_rd);
    id_entry.is_load = id_is_load;
    pipe_d           = '0;
    for (int k = 1; k < int'(DEPTH); k++) begin
      pipe_d[k] = (flush && SQUASH_MASK[k-1]) ? entry_t'('0) : pipe_q[k-1];
    end
    if (!stall && !flush) pipe_d[0] = id_entry;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pipe_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Table-driven bench for hazard_unit with a queue of expected per-cycle outputs.
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, flush;
  logic [2:0] flush_mask;
  logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic [3:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw, ld, br;
    logic       e_stall, e_flush;
    logic [2:0] e_mask;
    logic [1:0] e_s1, e_s2;
    logic       chk_sel;
    logic [3:0] e_cnt;
  } vec_t;

  typedef struct {
    int         tag;
    logic       e_stall, e_flush;
    logic [2:0] e_mask;
    logic [1:0] e_s1, e_s2;
    logic       chk_sel;
    logic [3:0] e_cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[19];

  hazard_unit #(.CNT_W(4)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .br_taken     (br_taken),
    .stall        (stall),
    .flush        (flush),
    .flush_mask   (flush_mask),
    .fwd_sel_rs1  (fwd_sel_rs1),
    .fwd_sel_rs2  (fwd_sel_rs2),
    .stall_cnt    (stall_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                              input logic u2, input int rd, input logic rw, input logic ld,
                              input logic br, input logic st, input logic fl, input int mask,
                              input int s1, input int s2, input logic chk, input int cnt);
    vec_t x;
    x.v = v; x.rs1 = 5'(rs1); x.u1 = u1; x.rs2 = 5'(rs2); x.u2 = u2; x.rd = 5'(rd);
    x.rw = rw; x.ld = ld; x.br = br; x.e_stall = st; x.e_flush = fl; x.e_mask = 3'(mask);
    x.e_s1 = 2'(s1); x.e_s2 = 2'(s2); x.chk_sel = chk; x.e_cnt = 4'(cnt);
    return x;
  endfunction

  task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, tag, act, exp);
    end
  endtask

  task automatic drive(input vec_t x, input int tag);
    exp_t e;
    id_valid = x.v; id_rs1 = x.rs1; id_use_rs1 = x.u1; id_rs2 = x.rs2; id_use_rs2 = x.u2;
    id_rd = x.rd; id_reg_write = x.rw; id_is_load = x.ld; br_taken = x.br;
    e.tag = tag; e.e_stall = x.e_stall; e.e_flush = x.e_flush; e.e_mask = x.e_mask;
    e.e_s1 = x.e_s1; e.e_s2 = x.e_s2; e.chk_sel = x.chk_sel; e.e_cnt = x.e_cnt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: got empty queue want one entry");
      return;
    end
    total--;
    e = sb.pop_front();
    cmp("stall", e.tag, 32'(stall), 32'(e.e_stall));
    cmp("flush", e.tag, 32'(flush), 32'(e.e_flush));
    cmp("flush_mask", e.tag, 32'(flush_mask), 32'(e.e_mask));
    if (e.chk_sel) begin
      cmp("fwd_sel_rs1", e.tag, 32'(fwd_sel_rs1), 32'(e.e_s1));
      cmp("fwd_sel_rs2", e.tag, 32'(fwd_sel_rs2), 32'(e.e_s2));
    end
    cmp("stall_cnt", e.tag, 32'(stall_cnt), 32'(e.e_cnt));
  endtask

  task automatic step(input vec_t x, input int tag);
    drive(x, tag);
    @(negedge CLK);
    check_out();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //            v rs1 u1 rs2 u2 rd rw ld br | st fl mk s1 s2 chk cnt
    tbl[0]  = mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1,  1, 1,  2, 1,  5, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1,  5, 1,  1, 1,  6, 1, 0, 0,  0, 0, 0, 1, 0, 1, 0);
    tbl[3]  = mk(1,  2, 1,  0, 0,  7, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mk(1,  7, 1,  7, 1,  8, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(1,  7, 1,  7, 1,  8, 1, 0, 0,  0, 0, 0, 2, 2, 1, 1);
    tbl[6]  = mk(1,  1, 1,  0, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[7]  = mk(1,  0, 1,  0, 1,  9, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[8]  = mk(1,  3, 1,  3, 1,  4, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[9]  = mk(1,  1, 1,  1, 1,  4, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[10] = mk(1,  4, 1,  9, 1, 10, 1, 0, 0,  0, 0, 0, 1, 3, 1, 1);
    tbl[11] = mk(1, 10, 0,  4, 1, 11, 1, 0, 0,  0, 0, 0, 0, 2, 1, 1);
    tbl[12] = mk(0,  0, 0,  0, 0, 12, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[13] = mk(1, 11, 1,  0, 0, 12, 1, 1, 0,  0, 0, 0, 2, 0, 1, 1);
    tbl[14] = mk(1, 12, 1,  0, 0, 13, 1, 0, 1,  0, 1, 1, 0, 0, 0, 1);
    tbl[15] = mk(1, 12, 1, 11, 1, 14, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[16] = mk(1,  0, 0,  0, 0, 15, 1, 1, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[17] = mk(1, 14, 1, 15, 1, 16, 1, 0, 0,  1, 0, 0, 0, 0, 1, 1);
    tbl[18] = mk(1, 14, 1, 15, 1, 16, 1, 0, 0,  0, 0, 0, 3, 2, 1, 2);

    RESET_N = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0; br_taken = 1'b0;

    // Outputs held quiet while in reset.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    cmp("rst_stall", -1, 32'(stall), 32'd0);
    cmp("rst_flush", -1, 32'(flush), 32'd0);
    cmp("rst_mask", -1, 32'(flush_mask), 32'd0);
    cmp("rst_sel1", -1, 32'(fwd_sel_rs1), 32'd0);
    cmp("rst_sel2", -1, 32'(fwd_sel_rs2), 32'd0);
    cmp("rst_cnt", -1, 32'(stall_cnt), 32'd0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;

    for (int i = 0; i < 19; i++) step(tbl[i], i);

    // Reset asserted in the middle of a load-use stall.
    step(mk(1, 2, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2), 100);
    drive(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 1, 0, 0, 0, 0, 1, 2), 101);
    @(negedge CLK);
    check_out();
    #1 RESET_N = 1'b0;
    #1;
    cmp("midrst_stall", 102, 32'(stall), 32'd0);
    cmp("midrst_cnt", 102, 32'(stall_cnt), 32'd0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    step(mk(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 103);

    // Self-dependent loads stall every other cycle; the 4-bit counter must stick at 15.
    for (int i = 0; i < 40; i++) begin
      step(mk(1, 7, 1, 0, 0, 7, 1, 1, 0, (i % 2) == 1, 0, 0, 0, 0, 0,
              ((i / 2) > 15) ? 15 : (i / 2)), 200 + i);
    end
    @(negedge CLK);
    cmp("sat_cnt", 300, 32'(stall_cnt), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter DEPTH, default 3: tracked in-flight stages after ID (slot 0 = EX, slot 1 = MEM, slot 2 = WB); legal range 2..6.
REQ-002 Parameter REG_AW, default 5: register-address width.
REQ-003 Parameter LOAD_READY, default 1: first slot index whose load result is forwardable; legal range 1..DEPTH-1.
REQ-004 Parameter FLUSH_SLOTS, default 1: number of younger slots squashed on a taken branch, counted from slot 0; legal range 0..DEPTH-1.
REQ-005 Parameter CNT_W, default 32: stall-counter width.
REQ-006 CLK  in  1  clock, rising edge.
REQ-007 RESET_N  in  1  reset, asynchronous, active-low.
REQ-008 id_valid  in  1  ID holds a real instruction.
REQ-009 id_rs1, id_rs2  in  REG_AW  source registers.
REQ-010 id_use_rs1, id_use_rs2  in  1  source actually read.
REQ-011 id_rd  in  REG_AW  destination register.
REQ-012 id_reg_write  in  1  instruction writes id_rd.
REQ-013 id_is_load  in  1  instruction is a load.
REQ-014 br_taken  in  1  branch resolved taken this cycle.
REQ-015 stall  out  1  hold PC and IF/ID; insert a bubble into EX.
REQ-016 flush  out  1  squash IF/ID and the younger stages (equal to br_taken).
REQ-017 flush_mask  out  DEPTH  bit k set = squash slot k.
REQ-018 fwd_sel_rs1, fwd_sel_rs2  out  clog2(DEPTH+1)  0 = register file; k+1 = forward from slot k.
REQ-019 stall_cnt  out  CNT_W  count of stall cycles.

Function
REQ-020 The block shall keep a DEPTH-entry tracking pipe; each entry holds {valid, rd, is_load}.
REQ-021 Each cycle the block shall shift entry k into entry k+1, and the oldest entry shall drop out.
REQ-022 When stall=0 and flush=0, entry 0 shall load {id_valid & id_reg_write & (id_rd!=0), id_rd, id_is_load}; otherwise entry 0 shall load a bubble (valid=0).
REQ-023 Per source, the match rule shall be:
  - consider only slots with valid=1 and rd equal to the source register;
  - select the lowest-index (youngest) matching slot;
  - a source equal to 0, or with use=0, shall never match.
REQ-024 The forward select for each source shall be combinational: it shall be k+1 for matched slot k, and 0 if there is no match.
REQ-025 Load-use: stall shall be 1 when id_valid=1 and either source matches a slot k < LOAD_READY whose is_load=1; in that case both fwd_sel outputs shall be 0.
REQ-026 Taken-branch priority: when br_taken=1, stall shall be 0, flush shall be 1, and flush_mask shall be ((1<<FLUSH_SLOTS)-1).
REQ-027 On the next edge after br_taken=1, the masked slots shall be cleared to valid=0 and the shift shall proceed.
REQ-028 br_taken together with a load-use condition: the flush shall win and no stall cycle shall be counted.
REQ-029 Stall latency: a load in ID directly followed by a dependent instruction shall give exactly LOAD_READY stall cycles.
REQ-030 stall_cnt shall increment on each edge with stall=1 and shall saturate at all-ones (no wrap).
REQ-031 The block shall be a pure function of the pipe contents and the inputs; no output shall depend on entries with valid=0.

Reset
REQ-032 While RESET_N=0, all entries shall have valid=0 and stall_cnt shall be 0.
REQ-033 During reset, stall, flush and flush_mask shall be 0 and both fwd_sel outputs shall be 0 (given br_taken=0).
REQ-034 A reset mid-stall shall drop the pending stall immediately; after release, the first cycle shall start with an empty pipe.

Structure
REQ-035 A shared package hazard_pkg shall hold:
  - the entry struct {valid, rd, is_load};
  - the default DEPTH, REG_AW and LOAD_READY constants;
  - the FWD_RF=0 constant;
  - a function giving the fwd_sel width.
REQ-036 One sub-module, fwd_match, shall exist: one instance per source; each is a priority encoder from the tracking pipe and one source register to {hit, slot, is_load}.

Verification
REQ-037 Forwarding from EX: add x5 then add x6,x5,x1 -> fwd_sel_rs1=1 and stall=0 on the second instruction.
REQ-038 Load-use: lw x7 then add x8,x7,x7 -> stall=1 for 1 cycle, then fwd_sel_rs1=fwd_sel_rs2=2, and stall_cnt=1.
REQ-039 Register x0: addi x0 then add x9,x0,x0 -> both fwd_sel=0 and stall=0.
REQ-040 Youngest wins: writes to x4 in slot 0 and slot 1, then a read of x4 -> fwd_sel=1.
REQ-041 Branch during load-use: br_taken=1 in the same cycle as a load-use condition -> stall=0, flush=1, flush_mask=3'b001, slot 0 invalid on the next cycle, and stall_cnt unchanged.
REQ-042 Reset and saturation: RESET_N low mid-stall -> stall=0 at once; with CNT_W=4 and 20 stall cycles -> stall_cnt=15.
